// File: rtl/load_unit.sv
// rtl/load_unit.sv - aligned word load with byte/half lane select, sign/zero extension and bus timeout
module load_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [2:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        misaligned,
    output logic        fault,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIM_I);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] cnt;
    logic          is_half, is_word, mis_in, timeout_hit;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext_v;

    // op[1:0]: 00 byte, 01 half, 1x word (covers the reserved encodings)
    assign is_half     = (op[1:0] == 2'b01);
    assign is_word     = op[1];
    assign mis_in      = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT != 0) && (cnt >= LIMIT);

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_valid = (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = mis_in ? DONE : REQ;
            REQ: begin
                // a completion on the timeout cycle still counts as normal
                if (mem_ready)        state_nxt = RESP;
                else if (timeout_hit) state_nxt = DONE;
            end
            RESP:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_v = rdata_q[{off_q, 3'b000} +: 8];
        half_v = rdata_q[{off_q[1], 4'b0000} +: 16];
        case (op_q)
            3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  ext_v = {24'h0, byte_v};
            3'b001:  ext_v = {{16{half_v[15]}}, half_v};
            3'b101:  ext_v = {16'h0, half_v};
            default: ext_v = rdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 3'b000;
            off_q      <= 2'b00;
            rdata_q    <= 32'h0;
            cnt        <= '0;
            result     <= 32'h0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            mem_addr   <= 32'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q       <= op;
                    off_q      <= address[1:0];
                    mem_addr   <= {address[31:2], 2'b00};
                    cnt        <= '0;
                    misaligned <= mis_in;
                    fault      <= 1'b0;
                    if (mis_in) result <= 32'h0;
                end
                REQ: begin
                    if (mem_ready) begin
                        rdata_q <= mem_rdata;
                    end else begin
                        if (timeout_hit) begin
                            fault  <= 1'b1;
                            result <= 32'h0;
                        end
                        if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
                    end
                end
                RESP:    result <= ext_v;
                default: ;
            endcase
        end
    end

endmodule
